multicycle_main_control: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath. It sequences the instruction register, the program counter, memory, the register file and the single shared ALU. Each instruction runs over 3-5 states. In every state it drives the 3-bit ALUop consumed by the ALU control unit and selects the ALU operand sources. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

---
 rtl/multicycle_main_control.sv | 267 ++++++++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// ---------------------------------------------------------------------------
// multicycle_main_control
//
// Main control FSM for the multi-cycle MIPS datapath. It steps each
// instruction through FETCH, DECODE and 1-3 execute states. In every state it
// drives the datapath strobes, the ALU operand selects and the 3-bit ALUop
// used by the ALU control unit. FETCH, MEMRD and MEMWR wait on mem_ready, so
// the sequence stalls while memory is slow.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset (state -> FETCH)
//   opcode     in   IR[31:26], valid from DECODE onward
//   zero       in   ALU zero flag (same cycle)
//   mem_ready  in   memory completes the current access this cycle
//   pc_en      out  PC load enable (branch condition already resolved)
//   iord       out  memory address: 0 = PC, 1 = ALUOut
//   mem_read   out  memory read request
//   mem_write  out  memory write request
//   ir_write   out  instruction register load
//   reg_dst    out  write register: 0 = rt, 1 = rd
//   mem_to_reg out  write data: 0 = ALUOut, 1 = MDR
//   reg_write  out  register file write enable
//   alu_src_a  out  ALU A: 0 = PC, 1 = A register
//   alu_src_b  out  ALU B: 00 B reg, 01 const 4, 10 ext imm, 11 sext imm<<2
//   ext_zero   out  1 = zero-extend immediate (andi/ori)
//   pc_source  out  PC input: 00 ALU result, 01 ALUOut, 10 jump target
//   alu_op     out  000 SUB,001 ADD,010 SLT,011 AND,100 OR,101 ADDU,
//                   110 SLTU,111 funct-decoded
//   illegal_op out  one-cycle pulse in DECODE for an unsupported opcode
//   state      out  current state (debug)
// ---------------------------------------------------------------------------
module multicycle_main_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               ext_zero,
    output logic [1:0]         pc_source,
    output logic [2:0]         alu_op,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BRANCH   = 4'd8,
        S_ITYPE_EX = 4'd9,
        S_ITYPE_WB = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALU_SUB   = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SLT   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_ADDU  = 3'b101;
    localparam logic [2:0] ALU_SLTU  = 3'b110;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    state_t state_q;
    state_t state_d;

    // NOTE: the state register is the only clocked element and uses
    // non-blocking assignment so every reader sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode. The cycle that leaves FETCH is the same
    // cycle that loads IR and PC, so ir_write and pc_en follow mem_ready.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d    = S_FETCH;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        ext_zero   = 1'b0;
        pc_source  = PCSRC_ALU;
        alu_op     = ALU_SUB;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                pc_source = PCSRC_ALU;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end

            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b = SRCB_BOFS;
                alu_op    = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = S_RTYPE_EX;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI:
                                    state_d = S_ITYPE_EX;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = mem_ready ? S_MEMWB : S_MEMRD;
            end

            S_MEMWB: begin
                reg_dst    = 1'b0;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_d   = mem_ready ? S_FETCH : S_MEMWR;
            end

            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_op    = ALU_FUNCT;
                state_d   = S_RTYPE_WB;
            end

            S_RTYPE_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_op    = ALU_SUB;
                pc_source = PCSRC_ALUOUT;
                if (opcode == OP_BEQ) begin
                    pc_en = zero;
                end else if (opcode == OP_BNE) begin
                    pc_en = ~zero;
                end
                state_d = S_FETCH;
            end

            S_ITYPE_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_ADDI:  alu_op = ALU_ADD;
                    OP_ADDIU: alu_op = ALU_ADDU;
                    OP_SLTI:  alu_op = ALU_SLT;
                    OP_SLTIU: alu_op = ALU_SLTU;
                    OP_ANDI: begin
                        alu_op   = ALU_AND;
                        ext_zero = 1'b1;
                    end
                    OP_ORI: begin
                        alu_op   = ALU_OR;
                        ext_zero = 1'b1;
                    end
                    default:  alu_op = ALU_ADD;
                endcase
                state_d = S_ITYPE_WB;
            end

            S_ITYPE_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end

            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_en     = 1'b1;
                state_d   = S_FETCH;
            end

            // Encodings 12-15 are unreachable; all outputs stay 0 and the
            // FSM falls back to FETCH.
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_main_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_main_control
//
// Self-checking bench for multicycle_main_control: a per-opcode vector table
// (latency and execute-state controls), hand sequences for memory stalls and
// asynchronous reset in MEMWR, and a randomized run against an instruction-
// level reference model that walks per-opcode state lists.
// ---------------------------------------------------------------------------
module tb_multicycle_main_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, ext_zero, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal_op;
    } ctl_t;

    ctl_t act;
    assign act = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_zero,
                  pc_source, alu_op, illegal_op};

    multicycle_main_control #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_zero   (ext_zero),
        .pc_source  (pc_source),
        .alu_op     (alu_op),
        .illegal_op (illegal_op),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, actual,
                     expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                           BNE = 6'b000101, JMP = 6'b000010, RTY = 6'b000000;

    function automatic bit is_itype(input logic [5:0] op);
        return op >= 6'b001000 && op <= 6'b001101;
    endfunction

    function automatic bit is_supported(input logic [5:0] op);
        return op == RTY || op == LW || op == SW || op == BEQ || op == BNE ||
               op == JMP || is_itype(op);
    endfunction

    // Instruction-level view: the states an instruction visits after FETCH.
    int prog[$];
    function automatic void load_prog(input logic [5:0] op);
        if (op == RTY)                   prog = '{1, 6, 7};
        else if (op == LW)               prog = '{1, 2, 3, 4};
        else if (op == SW)               prog = '{1, 2, 5};
        else if (op == BEQ || op == BNE) prog = '{1, 8};
        else if (op == JMP)              prog = '{1, 11};
        else if (is_itype(op))           prog = '{1, 9, 10};
        else                             prog = '{1};
    endfunction

    function automatic ctl_t exp_out(input int st, input logic [5:0] op,
                                     input logic z, input logic mr);
        ctl_t c;
        logic [2:0] itype_alu [6];
        itype_alu = '{3'b001, 3'b101, 3'b010, 3'b110, 3'b011, 3'b100};
        c = '0;
        case (st)
            0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_op = 3'b001;
                      c.ir_write = mr; c.pc_en = mr; end
            1:  begin c.alu_src_b = 2'b11; c.alu_op = 3'b001;
                      c.illegal_op = !is_supported(op); end
            2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 3'b001; end
            3:  begin c.mem_read = 1; c.iord = 1; end
            4:  begin c.mem_to_reg = 1; c.reg_write = 1; end
            5:  begin c.mem_write = 1; c.iord = 1; end
            6:  begin c.alu_src_a = 1; c.alu_op = 3'b111; end
            7:  begin c.reg_dst = 1; c.reg_write = 1; end
            8:  begin c.alu_src_a = 1; c.pc_source = 2'b01;
                      c.pc_en = (op == BEQ) ? z : !z; end
            9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10;
                      if (is_itype(op)) c.alu_op = itype_alu[op - 6'b001000];
                      c.ext_zero = (op == 6'b001100) || (op == 6'b001101); end
            10: begin c.reg_write = 1; end
            11: begin c.pc_source = 2'b10; c.pc_en = 1; end
            default: ;
        endcase
        return c;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic [5:0] op;
        logic       z;
        int         lat;     // cycles FETCH..last state, mem_ready high
        logic       ill2;    // illegal_op in DECODE
        int         st3;     // state after DECODE
        logic [2:0] alu3;    // alu_op there
        logic       ext3;
        logic       pcen3;
    } vec_t;

    vec_t vecs[16];

    logic [5:0] op_pool[14];

    initial begin : main
        int n;
        bit done;
        int exp_st;
        int lw_st[11];
        int lw_mr[11];
        int add_st[4];

        vecs[0]  = '{"rtype",  6'b000000, 0, 4, 0,  6, 3'b111, 0, 0};
        vecs[1]  = '{"lw",     6'b100011, 0, 5, 0,  2, 3'b001, 0, 0};
        vecs[2]  = '{"sw",     6'b101011, 0, 4, 0,  2, 3'b001, 0, 0};
        vecs[3]  = '{"beq_z1", 6'b000100, 1, 3, 0,  8, 3'b000, 0, 1};
        vecs[4]  = '{"beq_z0", 6'b000100, 0, 3, 0,  8, 3'b000, 0, 0};
        vecs[5]  = '{"bne_z1", 6'b000101, 1, 3, 0,  8, 3'b000, 0, 0};
        vecs[6]  = '{"bne_z0", 6'b000101, 0, 3, 0,  8, 3'b000, 0, 1};
        vecs[7]  = '{"j",      6'b000010, 0, 3, 0, 11, 3'b000, 0, 1};
        vecs[8]  = '{"addi",   6'b001000, 0, 4, 0,  9, 3'b001, 0, 0};
        vecs[9]  = '{"addiu",  6'b001001, 0, 4, 0,  9, 3'b101, 0, 0};
        vecs[10] = '{"slti",   6'b001010, 0, 4, 0,  9, 3'b010, 0, 0};
        vecs[11] = '{"sltiu",  6'b001011, 0, 4, 0,  9, 3'b110, 0, 0};
        vecs[12] = '{"andi",   6'b001100, 0, 4, 0,  9, 3'b011, 1, 0};
        vecs[13] = '{"ori",    6'b001101, 0, 4, 0,  9, 3'b100, 1, 0};
        vecs[14] = '{"ill3f",  6'b111111, 0, 2, 1,  0, 3'b001, 0, 1};
        vecs[15] = '{"ill03",  6'b000011, 0, 2, 1,  0, 3'b001, 0, 1};

        op_pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                    6'b000010, 6'b001000, 6'b001001, 6'b001010, 6'b001011,
                    6'b001100, 6'b001101, 6'b111111, 6'b011111};

        rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;

        // ---- reset values ----
        #3;
        check("rst_state", state, 0);
        check("rst_ctl_mr0", act, 19'h0_0000 | exp_out(0, 6'd0, 0, 0));
        mem_ready = 1'b1; #1;
        check("rst_ctl_mr1", act, exp_out(0, 6'd0, 0, 1));
        check("rst_irw_mr1", ir_write, 1);

        // ---- per-opcode table ----
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst_n = 1'b0; opcode = vecs[i].op; zero = vecs[i].z; mem_ready = 1'b1;
            @(negedge clk);
            rst_n = 1'b1;
            n = 1; done = 0;
            while (!done && n < 12) begin
                @(negedge clk); #1;
                n++;
                if (n == 2) check({vecs[i].name, "_illegal"}, illegal_op, vecs[i].ill2);
                if (n == 3) begin
                    check({vecs[i].name, "_state3"}, state, vecs[i].st3);
                    check({vecs[i].name, "_aluop3"}, alu_op, vecs[i].alu3);
                    check({vecs[i].name, "_extzero3"}, ext_zero, vecs[i].ext3);
                    check({vecs[i].name, "_pcen3"}, pc_en, vecs[i].pcen3);
                end
                if (state == 0) done = 1;
            end
            check({vecs[i].name, "_latency"}, n - 1, vecs[i].lat);
        end

        // ---- lw with FETCH and MEMRD stalls ----
        lw_st = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 0};
        lw_mr = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
        @(negedge clk);
        rst_n = 1'b0; opcode = LW; zero = 1'b0; mem_ready = lw_mr[0][0];
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k > 0) begin
                @(negedge clk);
                mem_ready = lw_mr[k][0];
            end
            #1;
            check($sformatf("lw_stall_state%0d", k), state, lw_st[k]);
            check($sformatf("lw_stall_ctl%0d", k), act,
                  exp_out(lw_st[k], LW, zero, mem_ready));
        end

        // ---- async reset while stalled in MEMWR ----
        @(negedge clk);
        rst_n = 1'b0; opcode = SW; mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;               // DECODE
        @(negedge clk); mem_ready = 1'b0; #1;  // MEMADR
        @(negedge clk); #1;               // MEMWR, stalled
        check("memwr_state", state, 5);
        check("memwr_write", mem_write, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_mem_write", mem_write, 0);
        check("arst_ctl", act, exp_out(0, SW, zero, 0));
        @(negedge clk);
        rst_n = 1'b1; opcode = RTY; mem_ready = 1'b1;
        add_st = '{1, 6, 7, 0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check($sformatf("post_rst_state%0d", k), state, add_st[k]);
        end

        // ---- randomized run against the instruction-level model ----
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_st = 0;
        prog.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (exp_st == 0) opcode = op_pool[$urandom_range(13, 0)];
            zero      = 1'($urandom_range(1, 0));
            mem_ready = ($urandom_range(9, 0) < 7);
            #1;
            check("rand_state", state, exp_st);
            check("rand_ctl", act, exp_out(exp_st, opcode, zero, mem_ready));
            check("rand_strobe_excl",
                  32'(ir_write) + 32'(reg_write) + 32'(mem_write) <= 1, 1);
            if ((exp_st == 0 || exp_st == 3 || exp_st == 5) && !mem_ready) begin
                // stalled on memory
            end else if (exp_st == 0) begin
                load_prog(opcode);
                exp_st = prog.pop_front();
            end else if (prog.size() == 0) begin
                exp_st = 0;
            end else begin
                exp_st = prog.pop_front();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
